// File: rtl/omp_ctrl.sv
// OMP iteration sequencer: drives argmax (A), MGS (B) and back-substitution (C)
// blocks, keeps the selected support set and guards every wait with a watchdog.
module omp_ctrl #(
    parameter int MAX_ITER = 32,
    parameter int TIMEOUT  = 4096
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [5:0] K_target,
    input  logic [2:0] M_limit_in,
    output logic       start_a,
    input  logic       done_a,
    input  logic [5:0] lambda_a,
    output logic       start_b,
    input  logic       done_b,
    output logic [5:0] lambda,
    output logic [4:0] current_i,
    output logic [2:0] M_limit,
    output logic       start_c,
    input  logic       done_c,
    input  logic [4:0] supp_rd_addr,
    output logic [5:0] supp_rd_data,
    output logic [5:0] n_support,
    output logic       busy,
    output logic       done,
    output logic       early_stop,
    output logic       timeout_err
);

    typedef enum logic [3:0] {
        IDLE, A_ST, A_WT, CHK, B_ST, B_WT, NXT, C_ST, C_WT, FIN, ERR
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [5:0]  r_keff;
    logic [5:0]  r_i;
    logic [5:0]  r_lambda;
    logic [5:0]  r_n;
    logic [2:0]  r_mlim;
    logic        r_es;
    logic        r_to;
    logic [15:0] r_wd;
    logic [5:0]  r_supp [32];

    logic [5:0]  w_keff;
    logic        w_hit;
    logic        w_wd_exp;
    logic        w_in_wt;

    assign w_keff = (K_target > 6'(MAX_ITER)) ? 6'(MAX_ITER) : K_target;
    assign w_wd_exp = (r_wd == 16'(TIMEOUT - 1));
    assign w_in_wt = (r_state == A_WT) || (r_state == B_WT) ||
                     (r_state == C_WT);

    // Entries at or beyond n_support are stale and must never match.
    always_comb begin
        w_hit = 1'b0;
        for (int j = 0; j < 32; j++) begin
            if ((6'(j) < r_n) && (r_supp[j] == r_lambda)) begin
                w_hit = 1'b1;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (start) begin
                    w_next = (w_keff == 6'd0) ? FIN : A_ST;
                end
            end
            A_ST: w_next = A_WT;
            A_WT: begin
                if (done_a) w_next = CHK;
                else if (w_wd_exp) w_next = ERR;
            end
            CHK:  w_next = w_hit ? C_ST : B_ST;
            B_ST: w_next = B_WT;
            B_WT: begin
                if (done_b) w_next = NXT;
                else if (w_wd_exp) w_next = ERR;
            end
            NXT:  w_next = ((r_i + 6'd1) == r_keff) ? C_ST : A_ST;
            C_ST: w_next = C_WT;
            C_WT: begin
                if (done_c) w_next = FIN;
                else if (w_wd_exp) w_next = ERR;
            end
            FIN:  w_next = IDLE;
            ERR:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_keff   <= 6'd0;
            r_i      <= 6'd0;
            r_lambda <= 6'd0;
            r_n      <= 6'd0;
            r_mlim   <= 3'd0;
            r_es     <= 1'b0;
            r_to     <= 1'b0;
            r_wd     <= 16'd0;
        end else begin
            r_state <= w_next;
            if ((r_state == IDLE) && start) begin
                r_keff <= w_keff;
                r_mlim <= M_limit_in;
                r_i    <= 6'd0;
                r_n    <= 6'd0;
                r_es   <= 1'b0;
                r_to   <= 1'b0;
            end
            if ((r_state == A_WT) && done_a) begin
                r_lambda <= lambda_a;
            end
            if (r_state == CHK) begin
                if (w_hit) r_es <= 1'b1;
                else r_n <= r_n + 6'd1;
            end
            if (r_state == NXT) begin
                r_i <= r_i + 6'd1;
            end
            if (w_next == ERR) begin
                r_to <= 1'b1;
            end
            r_wd <= w_in_wt ? r_wd + 16'd1 : 16'd0;
        end
    end

    always_ff @(posedge clk) begin
        if ((r_state == CHK) && !w_hit) begin
            r_supp[r_i[4:0]] <= r_lambda;
        end
    end

    assign start_a      = (r_state == A_ST);
    assign start_b      = (r_state == B_ST);
    assign start_c      = (r_state == C_ST);
    assign done         = (r_state == FIN) || (r_state == ERR);
    assign busy         = (r_state != IDLE) && !done;
    assign lambda       = r_lambda;
    assign current_i    = r_i[4:0];
    assign M_limit      = r_mlim;
    assign n_support    = r_n;
    assign early_stop   = r_es;
    assign timeout_err  = r_to;
    assign supp_rd_data = r_supp[supp_rd_addr];

endmodule
